fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the ARM968E-S pipeline. Owns the program counter
//   and drives the byte address into the combinational Instruction_Memory. Captures
//   the returned word into the IF/ID pipeline register. Handles hazard freeze,
//   branch redirect/flush and fetch-address faults.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded on reset
//   IMEM_BYTES  2048           instruction memory size in bytes; legal fetch range
//   PC_STEP     4              sequential PC increment in bytes
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous reset, active low
//   freeze_i       in   1   hazard stall from the hazard unit; hold PC and IF/ID
//   branch_taken_i in   1   redirect from EXE; load branch_addr_i and flush IF/ID
//   branch_addr_i  in   32  branch target byte address
//   imem_addr_o    out  32  fetch byte address to instruction memory (= PC)
//   imem_data_i    in   32  instruction word returned combinationally, same cycle
//   id_pc_o        out  32  IF/ID: address of captured instruction + PC_STEP
//   id_inst_o      out  32  IF/ID: captured instruction word
//   id_valid_o     out  1   IF/ID: 1 = id_inst_o is a real instruction
//   id_fault_o     out  1   IF/ID: 1 = fetch address was illegal
// BEHAVIOUR
//   Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Reset (rst_n=0, immediate, no clock needed):
//     pc=RESET_PC, id_pc_o=0, id_inst_o=0, id_valid_o=0, id_fault_o=0.
//   imem_addr_o = pc, combinational. No other logic on that path.
//   fault_c = (pc[1:0]!=0) | (pc > IMEM_BYTES-4), combinational, unsigned compare.
//   PC update on each rising edge, priority order:
//     1. branch_taken_i  -> pc <= branch_addr_i. Branch wins over freeze_i.
//     2. freeze_i        -> pc holds.
//     3. otherwise       -> pc <= pc + PC_STEP, modulo 2^32.
//       FFFF_FFFC wraps to 0000_0000.
//   IF/ID update on the same edge, same priority:
//     1. branch_taken_i  -> flush: id_inst_o=0, id_pc_o=0, id_valid_o=0,
//        id_fault_o=0. The wrong-path word is discarded.
//     2. freeze_i        -> all four IF/ID outputs hold.
//     3. otherwise       -> id_inst_o<=imem_data_i, id_pc_o<=pc+PC_STEP,
//        id_fault_o<=fault_c, id_valid_o<=~fault_c.
//        When fault_c=1, id_inst_o is loaded with 0, not memory data.
//   Latency: a word addressed in cycle N is visible on the IF/ID outputs after
//     edge N+1. This holds when there is no freeze or branch.
//   Unaligned or out-of-range branch_addr_i is loaded as-is. The fault is
//     reported when that PC is fetched. PC keeps stepping from there.
//     The fault is not sticky.
//   Reset asserted mid-stream overrides branch and freeze. The first fetch after
//     release is from RESET_PC.
//   Freeze held for K cycles: no PC advance and no lost or duplicated instruction.
// TESTING
//   1. Reset, then 4 free cycles with mem[0..15] = words W0..W3 -> imem_addr_o
//      steps 0,4,8,C. IF/ID shows W0/pc 4 after edge 1, then W1/8, W2/C.
//   2. freeze_i=1 for 3 cycles at pc=8 -> imem_addr_o stays 8. IF/ID holds W1/8.
//      On release, W2/C follows with no gap and no duplicate.
//   3. branch_taken_i=1, branch_addr_i=0x40, at pc=0xC -> next imem_addr_o=0x40.
//      IF/ID valid=0 for one cycle, then mem[0x40]/pc 0x44 is valid.
//   4. branch_taken_i and freeze_i both 1 -> branch wins: pc=target, IF/ID flushed.
//   5. Branch to 0x7FC then free-run -> 0x7FC valid, fault=0. Next, 0x800 gives
//      fault=1, valid=0, inst=0. Branch to 0x2 gives fault=1.
//   6. Drop rst_n mid-cycle at pc=0x20 -> all outputs reset immediately, with no
//      clock edge. After release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory addressing and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 2048,
  parameter int          PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_fault_o
);
  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        fault_c;
  assign imem_addr_o = pc;
  assign pc_seq      = pc + 32'(PC_STEP);
  assign fault_c     = (pc[1:0] != 2'b00) | (pc > LAST_WORD);
  // program counter: branch redirect beats freeze, otherwise step sequentially
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else pc <= branch_taken_i ? branch_addr_i : freeze_i ? pc : pc_seq;
  // IF/ID register: flush on branch, hold on freeze, else capture the fetched word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end else if (branch_taken_i) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end else if (!freeze_i) begin
      id_pc_o    <= pc_seq;
      id_inst_o  <= fault_c ? '0 : imem_data_i;
      id_valid_o <= ~fault_c;
      id_fault_o <= fault_c;
    end
endmodule
